// File: rtl/adder_sequencer_if.sv
// Bundle of host-side request/result signals and the byte-serial bus to
// adder_controller. The sequencer connects through the slave modport; the
// host/controller side (or a bench) connects through the master modport.
interface adder_sequencer_if;
   // host request side
   logic        start;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        cin_in;
   // adder_controller side
   logic [7:0]  inp;
   logic        setA;
   logic        setB;
   logic [1:0]  select;
   logic        cin;
   logic [7:0]  out;
   logic        cout;
   // host status/result side
   logic        busy;
   logic        done;
   logic [31:0] sum;
   logic        carry;

   modport slave (
      input  start, a_in, b_in, cin_in, out, cout,
      output inp, setA, setB, select, cin, busy, done, sum, carry
   );

   modport master (
      output start, a_in, b_in, cin_in, out, cout,
      input  inp, setA, setB, select, cin, busy, done, sum, carry
   );
endinterface

// File: rtl/adder_sequencer.sv
// Drives a byte-serial adder_controller: loads operand A then B one byte at a
// time (MSB first, SETUP/STROBE/HOLD per byte), then reads the four sum bytes
// back through select and reassembles the 32-bit sum plus carry.
// All outputs are registers decoded from the next state, so the strobes are
// glitch-free and change only on the clock edge (or on reset).
module adder_sequencer #(
   parameter int PHASE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   adder_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      READ   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Last value of the phase counter inside one phase / readback slot.
   localparam logic [7:0] LAST_CNT = 8'(PHASE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;       // cycle within the current phase
   logic [1:0]  sub_q, sub_d;       // 0=SETUP 1=STROBE 2=HOLD
   logic [1:0]  byte_q, byte_d;     // byte slot within a LOAD or READ state
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        cin_q, cin_d;
   logic [31:0] sum_q, sum_d;
   logic        carry_q, carry_d;
   logic [7:0]  inp_q, inp_d;
   logic        set_a_q, set_a_d;
   logic        set_b_q, set_b_d;
   logic [1:0]  select_q, select_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Byte idx of a word counted from the most significant byte.
   function automatic logic [7:0] msb_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] r;
      case (idx)
         2'd0:    r = w[31:24];
         2'd1:    r = w[23:16];
         2'd2:    r = w[15:8];
         default: r = w[7:0];
      endcase
      return r;
   endfunction

   // Next-state, counter, operand-latch and readback-capture logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sub_d   = sub_q;
      byte_d  = byte_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      case (state_q)
         IDLE, DONE: begin
            // DONE accepts start exactly like IDLE so transactions can run back to back
            if (bus.start) begin
               state_d = LOAD_A;
               cnt_d   = 8'd0;
               sub_d   = 2'd0;
               byte_d  = 2'd0;
               a_d     = bus.a_in;
               b_d     = bus.b_in;
               cin_d   = bus.cin_in;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD_A, LOAD_B: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = 8'd0;
               if (sub_q == 2'd2) begin
                  sub_d  = 2'd0;
                  byte_d = byte_q + 2'd1;   // wraps to 0 for the next state
                  if (byte_q == 2'd3) begin
                     state_d = (state_q == LOAD_A) ? LOAD_B : READ;
                  end else begin
                     state_d = state_q;
                  end
               end else begin
                  sub_d = sub_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         READ: begin
            // select_q equals byte_q here, so out belongs to this slot
            if (cnt_q == LAST_CNT) begin
               cnt_d  = 8'd0;
               byte_d = byte_q + 2'd1;
               sum_d[{byte_q, 3'b000} +: 8] = bus.out;
               if (byte_q == 2'd3) begin
                  carry_d = bus.cout;
                  state_d = DONE;
               end else begin
                  state_d = READ;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output is a plain register.
   always_comb begin
      inp_d    = 8'h00;
      set_a_d  = 1'b0;
      set_b_d  = 1'b0;
      select_d = 2'd0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_d)
         LOAD_A: begin
            inp_d   = msb_byte(a_d, byte_d);
            set_a_d = (sub_d == 2'd1);
            busy_d  = 1'b1;
         end
         LOAD_B: begin
            inp_d   = msb_byte(b_d, byte_d);
            set_b_d = (sub_d == 2'd1);
            busy_d  = 1'b1;
         end
         READ: begin
            select_d = byte_d;
            busy_d   = 1'b1;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         sub_q    <= 2'd0;
         byte_q   <= 2'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         cin_q    <= 1'b0;
         sum_q    <= 32'd0;
         carry_q  <= 1'b0;
         inp_q    <= 8'h00;
         set_a_q  <= 1'b0;
         set_b_q  <= 1'b0;
         select_q <= 2'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sub_q    <= sub_d;
         byte_q   <= byte_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         inp_q    <= inp_d;
         set_a_q  <= set_a_d;
         set_b_q  <= set_b_d;
         select_q <= select_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.inp    = inp_q;
   assign bus.setA   = set_a_q;
   assign bus.setB   = set_b_q;
   assign bus.select = select_q;
   assign bus.cin    = cin_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.sum    = sum_q;
   assign bus.carry  = carry_q;

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 Parameter: PHASE_CYCLES, default 4, cycles per strobe phase and per readback slot (legal range 1..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a transaction; sampled only in IDLE or DONE.
REQ-005 a_in  input  32  operand A, captured at start acceptance.
REQ-006 b_in  input  32  operand B, captured at start acceptance.
REQ-007 cin_in  input  1  carry-in, captured at start acceptance.
REQ-008 inp  output  8  byte bus to adder_controller.
REQ-009 setA / setB  output  1 each  load strobes to adder_controller.
REQ-010 select  output  2  sum-byte selector to adder_controller.
REQ-011 cin  output  1  carry-in to adder_controller.
REQ-012 out  input  8  selected sum byte from adder_controller.
REQ-013 cout  input  1  carry-out from adder_controller.
REQ-014 busy  output  1  transaction in progress.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 sum  output  32  reassembled sum; carry  output  1  captured cout.

Function
REQ-017 States SHALL be IDLE, LOAD_A, LOAD_B, READ, DONE; IDLE/DONE --start--> LOAD_A --4 bytes--> LOAD_B --4 bytes--> READ --4 slots--> DONE --no start--> IDLE.
REQ-018 Start acceptance SHALL latch a_in, b_in, cin_in; cin SHALL drive the latched value until the next acceptance.
REQ-019 Each byte slot SHALL be 3*PHASE_CYCLES cycles: SETUP (inp valid, strobe 0), STROBE (inp valid, strobe 1), HOLD (inp valid, strobe 0).
REQ-020 Bytes SHALL be sent MSB first: [31:24], [23:16], [15:8], [7:0]; LOAD_A uses setA, LOAD_B uses setB.
REQ-021 setA and setB SHALL never be high simultaneously; strobes SHALL be glitch-free registered outputs.
REQ-022 READ SHALL drive select = 0,1,2,3 in turn, PHASE_CYCLES cycles each, capturing out into sum[8*select+7 : 8*select] on the last cycle of the slot.
REQ-023 carry SHALL be captured from cout on the last cycle of the select=3 slot.
REQ-024 If start accepted at edge k: busy=1 for cycles k+1 .. k+28*PHASE_CYCLES; DONE occupies cycle k+28*PHASE_CYCLES+1 with done=1, busy=0.
REQ-025 sum and carry SHALL hold their values from DONE until the next READ capture overwrites them.
REQ-026 start while busy SHALL be ignored with no effect on latched operands.
REQ-027 start in the DONE cycle SHALL be accepted exactly as in IDLE (back-to-back transactions, no idle gap).
REQ-028 Outside LOAD states inp SHALL be 0x00; outside READ select SHALL be 0.

Reset
REQ-029 On reset assertion, immediately (asynchronously): state=IDLE, inp=0, setA=0, setB=0, select=0, cin=0, busy=0, done=0, sum=0, carry=0, all counters 0.
REQ-030 Reset mid-transaction SHALL abort it with no done pulse; first start after reset release begins a fresh LOAD_A.

Verification
REQ-031 A=0x030207FF, B=0x0123C010, cin_in=0, PHASE_CYCLES=4 -> inp sequence 03,02,07,FF with setA, then 01,23,C0,10 with setB; sum=0x0425C80F, carry=0, done at k+113.
REQ-032 A=0xFFFFFFFF, B=0x00000001, cin_in=0 -> sum=0x00000000, carry=1.
REQ-033 A=0, B=0, cin_in=1 -> sum=0x00000001, carry=0, cin held 1 throughout.
REQ-034 start pulsed mid-LOAD_B with different a_in -> ignored; result matches first operands; start in DONE cycle -> new busy begins next cycle.
REQ-035 reset asserted during STROBE of LOAD_A byte 2 -> setA drops same cycle, busy=0, no done; restart yields correct sum.
REQ-036 PHASE_CYCLES=1 -> strobe high exactly 1 cycle per byte, total busy 28 cycles, correct sum.
